// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the shift sequencer.
// Contents: the op codes from the main control unit, the shift-register commands,
// the shift-source mux selects, the amount-source selector and the FSM states.
package shift_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_SLLV = 3'b011,
    OP_SRLV = 3'b100,
    OP_SRAV = 3'b101,
    OP_LUI  = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'b000,
    CMD_LOAD = 3'b001,
    CMD_SHL  = 3'b010,
    CMD_SHR  = 3'b011,
    CMD_SRA  = 3'b100
  } cmd_e;

  typedef enum logic [1:0] {
    SRC_RT  = 2'b00,
    SRC_RS  = 2'b01,
    SRC_IMM = 2'b10
  } src_e;

  typedef enum logic [1:0] {
    AMT_SHAMT = 2'b00,
    AMT_RS    = 2'b01,
    AMT_FIXED = 2'b10
  } amt_src_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Handshake and command bundle between the main control unit and the shift sequencer.
// Ports carried:
//   start, op, shamt, rs_amt            control unit -> sequencer
//   src_sel, shift_cmd, shift_n,        sequencer -> datapath / control unit
//   reg_wr, busy, done, err
// Modports: master = control-unit side, slave = sequencer side.
interface shift_seq_ctrl_if #(
  parameter int AMT_W = 5
);
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] shamt;
  logic [AMT_W-1:0] rs_amt;
  logic [1:0]       src_sel;
  logic [2:0]       shift_cmd;
  logic [AMT_W-1:0] shift_n;
  logic             reg_wr;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, op, shamt, rs_amt,
    input  src_sel, shift_cmd, shift_n, reg_wr, busy, done, err
  );

  modport slave (
    input  start, op, shamt, rs_amt,
    output src_sel, shift_cmd, shift_n, reg_wr, busy, done, err
  );
endinterface

// File: rtl/shift_seq_ctrl_op_decode.sv
// Combinational op decoder for the shift sequencer.
// Ports:
//   op       in   3  op code from the control unit
//   src_sel  out     shift-source mux select for the op
//   dir_cmd  out     shift-register command used in the SHIFT state
//   amt_src  out     where the shift amount comes from
//   illegal  out  1  op code 111
module shift_seq_ctrl_op_decode
  import shift_seq_ctrl_pkg::*;
(
  input  logic [2:0] op,
  output src_e       src_sel,
  output cmd_e       dir_cmd,
  output amt_src_e   amt_src,
  output logic       illegal
);

  always_comb begin
    src_sel = SRC_RT;
    dir_cmd = CMD_NOP;
    amt_src = AMT_SHAMT;
    illegal = 1'b0;
    case (op)
      OP_SLL:  begin dir_cmd = CMD_SHL; amt_src = AMT_SHAMT; end
      OP_SRL:  begin dir_cmd = CMD_SHR; amt_src = AMT_SHAMT; end
      OP_SRA:  begin dir_cmd = CMD_SRA; amt_src = AMT_SHAMT; end
      OP_SLLV: begin dir_cmd = CMD_SHL; amt_src = AMT_RS;    end
      OP_SRLV: begin dir_cmd = CMD_SHR; amt_src = AMT_RS;    end
      OP_SRAV: begin dir_cmd = CMD_SRA; amt_src = AMT_RS;    end
      // LUI shifts the immediate left by a fixed amount.
      OP_LUI:  begin src_sel = SRC_IMM; dir_cmd = CMD_SHL; amt_src = AMT_FIXED; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multicycle sequencer for the shift datapath (3:1 source mux feeding the shift register).
// Takes one shift op, steps LOAD -> SHIFT -> WRITE, and pulses a register-bank write.
// Illegal ops produce a one-cycle done+err pulse instead. No data passes through here.
// Ports:
//   clk    in  clock, all state on the rising edge
//   reset  in  synchronous active-high, forces IDLE and clears all outputs
//   bus    slave side of shift_seq_ctrl_if (start/op/shamt/rs_amt in;
//          src_sel/shift_cmd/shift_n/reg_wr/busy/done/err out, all registered)
// Parameters: AMT_W amount width, LUI_AMT fixed LUI shift, SKIP_ZERO bypasses SHIFT on zero amount.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int AMT_W     = 5,
  parameter int LUI_AMT   = 16,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_ctrl_if.slave  bus
);

  state_e           state;
  src_e             src_q;
  cmd_e             dir_q;
  logic [AMT_W-1:0] amt_q;

  src_e             dec_src;
  cmd_e             dec_dir;
  amt_src_e         dec_amt_src;
  logic             dec_illegal;
  logic [AMT_W-1:0] new_amt;
  logic             accept;

  shift_seq_ctrl_op_decode u_decode (
    .op      (bus.op),
    .src_sel (dec_src),
    .dir_cmd (dec_dir),
    .amt_src (dec_amt_src),
    .illegal (dec_illegal)
  );

  always_comb begin
    new_amt = bus.shamt;
    case (dec_amt_src)
      AMT_RS:    new_amt = bus.rs_amt;
      AMT_FIXED: new_amt = AMT_W'(LUI_AMT);
      default:   new_amt = bus.shamt;
    endcase
  end

  // busy is the registered output, so a request is only taken in IDLE, WRITE or ERR.
  assign accept = bus.start && !bus.busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      src_q         <= SRC_RT;
      dir_q         <= CMD_NOP;
      amt_q         <= '0;
      bus.src_sel   <= SRC_RT;
      bus.shift_cmd <= CMD_NOP;
      bus.shift_n   <= '0;
      bus.reg_wr    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      // Strobes last one cycle unless a branch below re-asserts them.
      bus.reg_wr <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;

      case (state)
        ST_IDLE, ST_WRITE, ST_ERR: begin
          if (accept) begin
            // Latch the decoded op so the inputs are free after this edge.
            src_q <= dec_src;
            dir_q <= dec_dir;
            amt_q <= new_amt;
            if (dec_illegal) begin
              state         <= ST_ERR;
              bus.src_sel   <= SRC_RT;
              bus.shift_cmd <= CMD_NOP;
              bus.shift_n   <= '0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              bus.err       <= 1'b1;
            end else begin
              state         <= ST_LOAD;
              bus.src_sel   <= dec_src;
              bus.shift_cmd <= CMD_LOAD;
              bus.shift_n   <= '0;
              bus.busy      <= 1'b1;
            end
          end else begin
            state         <= ST_IDLE;
            bus.src_sel   <= SRC_RT;
            bus.shift_cmd <= CMD_NOP;
            bus.shift_n   <= '0;
            bus.busy      <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (SKIP_ZERO && (amt_q == '0)) begin
            state         <= ST_WRITE;
            bus.src_sel   <= src_q;
            bus.shift_cmd <= CMD_NOP;
            bus.shift_n   <= '0;
            bus.busy      <= 1'b0;
            bus.reg_wr    <= 1'b1;
            bus.done      <= 1'b1;
          end else begin
            state         <= ST_SHIFT;
            bus.src_sel   <= src_q;
            bus.shift_cmd <= dir_q;
            bus.shift_n   <= amt_q;
            bus.busy      <= 1'b1;
          end
        end

        ST_SHIFT: begin
          state         <= ST_WRITE;
          bus.src_sel   <= src_q;
          bus.shift_cmd <= CMD_NOP;
          bus.shift_n   <= '0;
          bus.busy      <= 1'b0;
          bus.reg_wr    <= 1'b1;
          bus.done      <= 1'b1;
        end

        default: begin
          state         <= ST_IDLE;
          bus.src_sel   <= SRC_RT;
          bus.shift_cmd <= CMD_NOP;
          bus.shift_n   <= '0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl: two instances (SKIP_ZERO=1 and SKIP_ZERO=0) driven with the
// same stimulus, each compared every cycle against a schedule-based reference model.
module tb_shift_seq_ctrl;

  typedef struct packed {
    logic [1:0] src;
    logic [2:0] cmd;
    logic [4:0] n;
    logic       wr;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  logic clk;
  logic reset;

  shift_seq_ctrl_if #(.AMT_W(5)) bus_sk ();
  shift_seq_ctrl_if #(.AMT_W(5)) bus_ns ();

  shift_seq_ctrl #(.AMT_W(5), .LUI_AMT(16), .SKIP_ZERO(1'b1)) u_dut_sk (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_sk)
  );

  shift_seq_ctrl #(.AMT_W(5), .LUI_AMT(16), .SKIP_ZERO(1'b0)) u_dut_ns (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: each accepted op becomes a list of per-cycle output records;
  // pos indexes the record currently on the outputs, past the end means idle.
  exp_t sched [2][3];
  int   len [2];
  int   pos [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic exp_t cur(input int i);
    exp_t e;
    e = '0;
    if (pos[i] < len[i]) e = sched[i][pos[i]];
    return e;
  endfunction

  task automatic build(input int i, input logic [2:0] op, input logic [4:0] sh, input logic [4:0] rs);
    exp_t e;
    logic [4:0] amt;
    logic [2:0] dir;
    logic [1:0] src;
    bit skip;
    skip = (i == 0);
    pos[i] = 0;
    if (op == 3'd7) begin
      e = '0; e.done = 1'b1; e.err = 1'b1;
      sched[i][0] = e;
      len[i] = 1;
    end else begin
      src = (op == 3'd6) ? 2'b10 : 2'b00;
      amt = (op < 3'd3) ? sh : (op < 3'd6) ? rs : 5'd16;
      if (op == 3'd0 || op == 3'd3 || op == 3'd6) dir = 3'b010;
      else if (op == 3'd1 || op == 3'd4)          dir = 3'b011;
      else                                        dir = 3'b100;
      len[i] = 0;
      e = '0; e.src = src; e.cmd = 3'b001; e.busy = 1'b1;
      sched[i][len[i]] = e; len[i]++;
      if (!(skip && amt == 5'd0)) begin
        e = '0; e.src = src; e.cmd = dir; e.n = amt; e.busy = 1'b1;
        sched[i][len[i]] = e; len[i]++;
      end
      e = '0; e.src = src; e.wr = 1'b1; e.done = 1'b1;
      sched[i][len[i]] = e; len[i]++;
    end
  endtask

  task automatic model_edge(input logic rst, input logic st, input logic [2:0] op,
                            input logic [4:0] sh, input logic [4:0] rs);
    for (int i = 0; i < 2; i++) begin
      exp_t c;
      c = cur(i);
      if (rst) begin
        len[i] = 0;
        pos[i] = 0;
      end else if (st && !c.busy) begin
        build(i, op, sh, rs);
      end else if (pos[i] < len[i]) begin
        pos[i]++;
      end
    end
  endtask

  task automatic compare_all();
    exp_t e;
    e = cur(0);
    chk("sk.src_sel",   32'(bus_sk.src_sel),   32'(e.src));
    chk("sk.shift_cmd", 32'(bus_sk.shift_cmd), 32'(e.cmd));
    chk("sk.shift_n",   32'(bus_sk.shift_n),   32'(e.n));
    chk("sk.reg_wr",    32'(bus_sk.reg_wr),    32'(e.wr));
    chk("sk.busy",      32'(bus_sk.busy),      32'(e.busy));
    chk("sk.done",      32'(bus_sk.done),      32'(e.done));
    chk("sk.err",       32'(bus_sk.err),       32'(e.err));
    e = cur(1);
    chk("ns.src_sel",   32'(bus_ns.src_sel),   32'(e.src));
    chk("ns.shift_cmd", 32'(bus_ns.shift_cmd), 32'(e.cmd));
    chk("ns.shift_n",   32'(bus_ns.shift_n),   32'(e.n));
    chk("ns.reg_wr",    32'(bus_ns.reg_wr),    32'(e.wr));
    chk("ns.busy",      32'(bus_ns.busy),      32'(e.busy));
    chk("ns.done",      32'(bus_ns.done),      32'(e.done));
    chk("ns.err",       32'(bus_ns.err),       32'(e.err));
  endtask

  task automatic step(input logic rst, input logic st, input logic [2:0] op,
                      input logic [4:0] sh, input logic [4:0] rs);
    @(negedge clk);
    reset         = rst;
    bus_sk.start  = st;  bus_ns.start  = st;
    bus_sk.op     = op;  bus_ns.op     = op;
    bus_sk.shamt  = sh;  bus_ns.shamt  = sh;
    bus_sk.rs_amt = rs;  bus_ns.rs_amt = rs;
    @(posedge clk);
    model_edge(rst, st, op, sh, rs);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'd0, 5'd0, 5'd0);
  endtask

  initial begin
    logic       r_rst;
    logic       r_st;
    logic [2:0] r_op;
    logic [4:0] r_sh;
    logic [4:0] r_rs;
    len[0] = 0; len[1] = 0; pos[0] = 0; pos[1] = 0;
    reset = 1'b1;
    bus_sk.start = 1'b1; bus_ns.start = 1'b1;
    bus_sk.op = 3'd0;    bus_ns.op = 3'd0;
    bus_sk.shamt = 5'd4; bus_ns.shamt = 5'd4;
    bus_sk.rs_amt = 5'd0; bus_ns.rs_amt = 5'd0;

    // Reset held two cycles with start asserted.
    step(1'b1, 1'b1, 3'd0, 5'd4, 5'd0);
    step(1'b1, 1'b1, 3'd0, 5'd4, 5'd0);
    // SLL by 4.
    step(1'b0, 1'b1, 3'd0, 5'd4, 5'd0);  idle(3);
    // SRAV with rs_amt 31; shamt must be ignored.
    step(1'b0, 1'b1, 3'd5, 5'd7, 5'd31); idle(3);
    // LUI: immediate source, fixed 16.
    step(1'b0, 1'b1, 3'd6, 5'd3, 5'd0);  idle(3);
    // SRL by zero: bypass on one instance, SHIFT n=0 on the other.
    step(1'b0, 1'b1, 3'd1, 5'd0, 5'd9);  idle(3);
    // Illegal op.
    step(1'b0, 1'b1, 3'd7, 5'd1, 5'd1);  idle(1);
    // Start held high: ignored while busy, accepted in WRITE.
    step(1'b0, 1'b1, 3'd2, 5'd5, 5'd0);
    step(1'b0, 1'b1, 3'd3, 5'd6, 5'd1);
    step(1'b0, 1'b1, 3'd4, 5'd0, 5'd2);
    step(1'b0, 1'b1, 3'd0, 5'd2, 5'd0);
    idle(4);
    // Reset while in SHIFT aborts without reg_wr.
    step(1'b0, 1'b1, 3'd0, 5'd9, 5'd0);
    step(1'b0, 1'b0, 3'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 3'd0, 5'd0, 5'd0);
    idle(3);

    for (int k = 0; k < 800; k++) begin
      r_rst = ($urandom_range(0, 49) == 0);
      r_st  = 1'($urandom_range(0, 1));
      r_op  = 3'($urandom_range(0, 7));
      r_sh  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r_rs  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step(r_rst, r_st, r_op, r_sh, r_rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
